synaptic_weight_accumulator: RTL
================================

Name: synaptic_weight_accumulator

Overview:
- Upstream stage of the conductance LIF neuron unit.
- During a timestep it collects incoming synaptic events (target neuron, signed weight, excitatory/inhibitory) into per-neuron ExWeightSum/InWeightSum registers.
- At timestep end it streams the sums, one neuron per handshake, to the neuron-update pipeline and clears each entry as it is read.

Parameters:
- NUM_NEURONS, 16, number of neurons tracked (1..256).
- NEURON_ID_WIDTH, 8, width of neuron index fields.
- INTEGER_WIDTH, 32, integer bits of fixed-point data.
- DATA_WIDTH_FRAC, 32, fractional bits of fixed-point data.
- DATA_WIDTH, 64, INTEGER_WIDTH+DATA_WIDTH_FRAC; signed Q32.32 width of weights and sums.

Ports:
- Clock  in  1  single system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- SynValid  in  1  synaptic event present.
- SynReady  out  1  accumulator can accept an event.
- SynNeuronID  in  NEURON_ID_WIDTH  target neuron index.
- SynWeight  in  DATA_WIDTH  signed Q32.32 weight.
- SynInhib  in  1  0 = add to Ex sum; 1 = add to In sum.
- StartDrain  in  1  single-cycle pulse, end of timestep.
- OutValid  out  1  drained sum pair valid.
- OutReady  in  1  downstream accepts the pair.
- OutNeuronID  out  NEURON_ID_WIDTH  index of the drained pair.
- ExWeightSum  out  DATA_WIDTH  signed excitatory sum.
- InWeightSum  out  DATA_WIDTH  signed inhibitory sum.
- DrainDone  out  1  one-cycle pulse after the last pair is accepted.
- SatFlag  out  1  sticky: a saturation occurred this timestep.
- DropFlag  out  1  sticky: an out-of-range ID was received this timestep.

Behaviour:
- Storage: two arrays of NUM_NEURONS signed DATA_WIDTH registers (Ex, In), plus a drain index Idx.
- Reset (async, any state, including mid-drain):
  - all sums = 0, Idx = 0, state = ACCUM.
  - SynReady = 1; OutValid, DrainDone, SatFlag, DropFlag = 0.
  - OutNeuronID, ExWeightSum, InWeightSum = 0.
- States: ACCUM, DRAIN, DONE.
- ACCUM:
  - SynReady = 1; an event is accepted on any edge where SynValid=1.
  - Single-cycle read-modify-write: the target sum is updated at the accept edge. Back-to-back events to the same neuron accumulate correctly, with no bubbles or hazards.
  - Addition is signed and saturating to +(2^(DATA_WIDTH-1)-1) / -2^(DATA_WIDTH-1). On saturation, SatFlag is set.
  - SynNeuronID >= NUM_NEURONS: the event is accepted, discarded, and DropFlag is set.
  - StartDrain=1 moves to DRAIN at the next edge. An event accepted in the same cycle as StartDrain is included in this timestep's sums.
- DRAIN:
  - SynReady = 0.
  - OutValid = 1 starting the cycle after StartDrain; first Idx = 0.
  - OutNeuronID = Idx; ExWeightSum/InWeightSum = Ex[Idx]/In[Idx], combinationally from the arrays.
  - Outputs stay stable while OutReady = 0.
  - On OutValid&OutReady: Ex[Idx] and In[Idx] are cleared to 0 and Idx increments.
  - When Idx = NUM_NEURONS-1 is accepted: Idx returns to 0 and the state moves to DONE.
  - StartDrain is ignored in DRAIN and DONE.
- DONE (one cycle):
  - DrainDone = 1, OutValid = 0, SynReady = 0.
  - SatFlag and DropFlag clear at the exit edge.
  - Next state is ACCUM.
- Outside DRAIN: OutValid = 0 and the data outputs hold 0.
- Latency figures:
  - Event to visible sum: 1 cycle.
  - StartDrain to first OutValid: 1 cycle.
  - Full drain with OutReady held high: NUM_NEURONS cycles + 1 DONE cycle.
- Width rules: SynWeight is used at full width with no truncation. The saturating add uses a DATA_WIDTH+1 intermediate.

Test Plan:
- Reset, then events (n3, +1.5, Ex), (n3, +2.25, Ex), (n3, -0.5, In) back-to-back, then StartDrain with OutReady=1 -> 16 pairs at consecutive cycles; n3 = Ex 0x00000003_C0000000, In 0xFFFFFFFF_80000000; all others 0; DrainDone 1 cycle after the n15 pair; second drain is all zero.
- Drain with OutReady toggling 1,0,0,1,... -> each pair held stable while OutReady=0; no index skipped or repeated; 16 accepted transfers total; SynReady=0 throughout.
- Event (n7, 0x7FFFFFFF_00000000, Ex) twice -> Ex[7] = 0x7FFFFFFF_FFFFFFFF and SatFlag=1; negative counterpart saturates to 0x80000000_00000000; SatFlag clears after DONE.
- Event with SynNeuronID=20 -> accepted, no sum changes, DropFlag=1 until DONE.
- SynValid=1 coincident with StartDrain on n0 weight +1.0 -> pair n0 shows Ex=0x00000001_00000000; events presented during DRAIN are not accepted until the cycle after DrainDone.
- Reset asserted mid-drain at Idx=5 -> outputs immediately zero, state ACCUM, SynReady=1; a subsequent drain returns all zero sums.

Source files
------------

// File: rtl/synaptic_weight_accumulator.sv
// Per-neuron excitatory/inhibitory weight accumulator.
// Sums synaptic events over a timestep, then drains one saturated Q32.32 pair per handshake.
module synaptic_weight_accumulator #(
  parameter int NUM_NEURONS     = 16,
  parameter int NEURON_ID_WIDTH = 8,
  parameter int INTEGER_WIDTH   = 32,
  parameter int DATA_WIDTH_FRAC = 32,
  parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       SynValid,
  output logic                       SynReady,
  input  logic [NEURON_ID_WIDTH-1:0] SynNeuronID,
  input  logic [DATA_WIDTH-1:0]      SynWeight,
  input  logic                       SynInhib,
  input  logic                       StartDrain,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [NEURON_ID_WIDTH-1:0] OutNeuronID,
  output logic [DATA_WIDTH-1:0]      ExWeightSum,
  output logic [DATA_WIDTH-1:0]      InWeightSum,
  output logic                       DrainDone,
  output logic                       SatFlag,
  output logic                       DropFlag,
  output logic [1:0]                 DebugState
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [NEURON_ID_WIDTH:0] NUM_IDS = (NEURON_ID_WIDTH + 1)'(NUM_NEURONS);
  localparam logic [DATA_WIDTH-1:0] SUM_MAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SUM_MIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] ex_sum [NUM_NEURONS];
  logic [DATA_WIDTH-1:0] in_sum [NUM_NEURONS];
  logic                  sat_flag, drop_flag;

  logic                  accept, out_fire, id_ok, sat;
  logic [IDX_W-1:0]      syn_idx;
  logic [DATA_WIDTH-1:0] cur_sum, upd_sum;
  logic [DATA_WIDTH:0]   wide_sum;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // SynReady and OutValid depend only on state, never on the partner's valid/ready.
  always_comb begin
    accept   = (state == ACCUM) && SynValid;
    id_ok    = {1'b0, SynNeuronID} < NUM_IDS;
    syn_idx  = SynNeuronID[IDX_W-1:0];
    cur_sum  = SynInhib ? in_sum[syn_idx] : ex_sum[syn_idx];
    // One extra sign bit: overflow shows up as disagreement of the top two bits.
    wide_sum = {cur_sum[DATA_WIDTH-1], cur_sum} + {SynWeight[DATA_WIDTH-1], SynWeight};
    sat      = wide_sum[DATA_WIDTH] != wide_sum[DATA_WIDTH-1];
    upd_sum  = sat ? (wide_sum[DATA_WIDTH] ? SUM_MIN : SUM_MAX) : wide_sum[DATA_WIDTH-1:0];
  end

  always_comb begin
    state_next  = state;
    SynReady    = 1'b0;
    OutValid    = 1'b0;
    DrainDone   = 1'b0;
    OutNeuronID = '0;
    ExWeightSum = '0;
    InWeightSum = '0;
    case (state)
      ACCUM: begin
        SynReady = 1'b1;
        if (StartDrain) state_next = DRAIN;
      end
      DRAIN: begin
        OutValid    = 1'b1;
        OutNeuronID = NEURON_ID_WIDTH'(idx);
        ExWeightSum = ex_sum[idx];
        InWeightSum = in_sum[idx];
        if (OutReady && (idx == LAST_IDX)) state_next = DONE;
      end
      DONE: begin
        DrainDone  = 1'b1;
        state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
    out_fire = OutValid && OutReady;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= ACCUM;
      idx       <= '0;
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        ex_sum[i] <= '0;
        in_sum[i] <= '0;
      end
    end else begin
      state <= state_next;
      // Reading a pair clears it so the next timestep starts from zero.
      if (out_fire) begin
        ex_sum[idx] <= '0;
        in_sum[idx] <= '0;
        idx         <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
      if (accept) begin
        if (id_ok) begin
          if (SynInhib) in_sum[syn_idx] <= upd_sum;
          else          ex_sum[syn_idx] <= upd_sum;
          if (sat) sat_flag <= 1'b1;
        end else begin
          drop_flag <= 1'b1;
        end
      end
      if (state == DONE) begin
        sat_flag  <= 1'b0;
        drop_flag <= 1'b0;
      end
    end
  end

  assign SatFlag    = sat_flag;
  assign DropFlag   = drop_flag;
  assign DebugState = state;

endmodule
